// File: rtl/onehot_pkg.sv
// Shared types and helpers for the registered one-hot decoder family.
package onehot_pkg;

    localparam int unsigned MAX_N = 256;

    typedef logic [MAX_N-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    // One-hot of sel at width n; zero when sel is out of range.
    function automatic vec_t onehot_of(input int unsigned sel, input int unsigned n);
        vec_t v;
        v = '0;
        if ((sel < n) && (sel < MAX_N)) begin
            v = vec_t'(1) << sel;
        end
        return v;
    endfunction

    function automatic logic is_onehot0(input vec_t v);
        return ((v & (v - vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/onehot_rotator.sv
// Combinational rotate-left-by-one of an N-bit vector, flagging top-bit wrap.
// Zero latency; no flow control.
module onehot_rotator #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_vec,
    output logic [N-1:0] o_vec,
    output logic         o_wrap
);

    assign o_vec  = {i_vec[N-2:0], i_vec[N-1]};
    assign o_wrap = i_vec[N-1];

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with hold/pulse/scan modes and range error.
// One cycle from load or step to out_o; no backpressure, every request is taken.
module onehot_decoder_seq
    import onehot_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int OUT_N = 8,
    parameter int PULSE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             in_valid_i,
    input  logic [SEL_W-1:0] in_sel_i,
    input  logic             scan_en_i,
    input  logic             step_i,
    output logic [OUT_N-1:0] out_o,
    output logic             out_valid_o,
    output logic             err_o,
    output logic             wrap_o
);

    localparam int unsigned N_U = OUT_N;

    if ((SEL_W < 1) || (SEL_W > 16) || (OUT_N < 2) || (OUT_N > (2 ** SEL_W)) ||
        (OUT_N > MAX_N)) begin : g_bad_params
        $fatal(1, "onehot_decoder_seq: OUT_N must lie in 2..2**SEL_W");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OUT_N-1:0] r_out;
    logic [OUT_N-1:0] w_out_nxt;
    logic             r_out_vld;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;

    logic [OUT_N-1:0] w_dec;
    logic             w_sel_oor;
    logic [OUT_N-1:0] w_rot;
    logic             w_rot_wrap;

    // Range check on the full-width select, never a truncated copy.
    assign w_sel_oor = (32'(in_sel_i) >= N_U);
    assign w_dec     = OUT_N'(onehot_of(32'(in_sel_i), N_U));

    onehot_rotator #(
        .N (OUT_N)
    ) u_rot (
        .i_vec  (r_out),
        .o_vec  (w_rot),
        .o_wrap (w_rot_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_err_nxt   = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (clear_i) begin
            w_state_nxt = IDLE;
            w_out_nxt   = '0;
        end else if (in_valid_i) begin
            if (w_sel_oor) begin
                w_state_nxt = IDLE;
                w_out_nxt   = '0;
                w_err_nxt   = 1'b1;
            end else begin
                w_state_nxt = scan_en_i ? SCAN : HOLD;
                w_out_nxt   = w_dec;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_out_nxt = '0;
                end
                HOLD: begin
                    if (PULSE != 0) begin
                        w_state_nxt = IDLE;
                        w_out_nxt   = '0;
                    end
                end
                SCAN: begin
                    if (step_i) begin
                        w_out_nxt  = w_rot;
                        w_wrap_nxt = w_rot_wrap;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_out_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_out     <= '0;
            r_out_vld <= 1'b0;
            r_err     <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out     <= w_out_nxt;
            r_out_vld <= |w_out_nxt;
            r_err     <= w_err_nxt;
            r_wrap    <= w_wrap_nxt;
        end
    end

    assign out_o       = r_out;
    assign out_valid_o = r_out_vld;
    assign err_o       = r_err;
    assign wrap_o      = r_wrap;

    a_onehot0 : assert property (@(posedge clk) disable iff (rst)
        is_onehot0(vec_t'(r_out)) && (r_out_vld == (|r_out)));

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder. It generalises the 3-to-8 combinational decoder to any select width and output count.
- Adds the following over the combinational version:
  - valid-qualified loading;
  - out-of-range error detection;
  - level or pulse output mode;
  - a walking-one scan mode with wrap indication.
- Drives chip-select, row-select and channel-strobe fan-out in the datapath, where a glitch-free registered one-hot is required.

Parameters:
- SEL_W, 3, width of the binary select input.
- OUT_N, 8, number of one-hot outputs; legal range 2..2**SEL_W.
- PULSE, 0, 0 = loaded output holds until changed; 1 = loaded output is a single-cycle strobe.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear_i  input  1  synchronous clear of output and state.
- in_valid_i  input  1  load request; in_sel_i is sampled when high.
- in_sel_i  input  SEL_W  binary select value.
- scan_en_i  input  1  sampled with in_valid_i: 1 = enter SCAN after the load, 0 = enter HOLD.
- step_i  input  1  in SCAN, advance the walking one by one position.
- out_o  output  OUT_N  registered one-hot output (all zero when idle).
- out_valid_o  output  1  high whenever out_o is non-zero.
- err_o  output  1  one-cycle flag: the last load had in_sel_i >= OUT_N.
- wrap_o  output  1  one-cycle flag: a scan step moved the one from bit OUT_N-1 to bit 0.

Behaviour:
- Reset and clocking:
  - Clock is clk; reset is rst, asynchronous and active-high.
  - While rst is high: out_o=0, out_valid_o=0, err_o=0, wrap_o=0, state=IDLE.
  - Deasserting rst mid-operation resumes from IDLE. No pending load survives reset.
- All outputs are registered. Latency from in_valid_i or step_i to out_o is 1 cycle.
- States: IDLE (out_o=0), HOLD (static one-hot), SCAN (walking one).
- Priority each cycle: clear_i > in_valid_i > step_i.
- clear_i=1:
  - Next cycle out_o=0, out_valid_o=0, err_o=0, wrap_o=0, state=IDLE.
  - Takes effect in any state.
- in_valid_i=1 and in_sel_i < OUT_N, in any state:
  - Next cycle out_o = 1 << in_sel_i, out_valid_o=1, err_o=0.
  - Next state is SCAN if scan_en_i=1, else HOLD.
  - This overrides any current HOLD or SCAN content.
- in_valid_i=1 and in_sel_i >= OUT_N:
  - Next cycle out_o=0, out_valid_o=0, err_o=1 for exactly one cycle.
  - Next state is IDLE.
  - This case is reachable only when OUT_N < 2**SEL_W.
- HOLD:
  - PULSE=0: out_o holds until the next clear_i or load.
  - PULSE=1: out_o is high for exactly one cycle, then returns to 0 and the state goes to IDLE.
  - step_i is ignored in HOLD.
- SCAN:
  - step_i=1: rotate out_o left by one (bit k to bit k+1). From bit OUT_N-1 the one moves to bit 0 and wrap_o=1 for that one cycle.
  - step_i=0: out_o holds.
  - PULSE does not apply in SCAN.
  - Continuous step_i produces one wrap_o every OUT_N cycles.
- IDLE: step_i is ignored; out_o stays 0.
- Simultaneous in_valid_i and step_i: the load wins, step_i is dropped and wrap_o=0.
- Width rules:
  - Compute the decode as a width-OUT_N shift of 1.
  - Do the range check at full SEL_W width; never truncate the select before comparing.
- Invariant: out_o is always zero or exactly one-hot.
- Elaboration check: OUT_N outside 2..2**SEL_W is a fatal error.

Decomposition:
- Shared package onehot_pkg holds:
  - the state enum (IDLE, HOLD, SCAN);
  - the function onehot_of(sel, n), which returns the width-n one-hot or 0 when sel >= n;
  - the function is_onehot0 for assertions.
- One natural sub-module: onehot_rotator. It is a combinational width-OUT_N rotate-left-by-one with a wrap flag, reused elsewhere for round-robin pointers.
- The FSM and output registers stay in the top module.

Test Plan:
1. Reset, then load: rst pulse then in_valid_i=1, in_sel_i=5, scan_en_i=0 (defaults) -> one cycle later out_o=8'b0010_0000 and out_valid_o=1. The value holds for 10 idle cycles.
2. Exhaustive sweep: load in_sel_i=0..7 on consecutive cycles -> out_o follows 1<<sel with 1-cycle latency. Assertion: out_o is always zero or one-hot.
3. Scan and wrap: load in_sel_i=6 with scan_en_i=1, then step_i=1 for 3 cycles -> out_o = 0x40, 0x80, 0x01, 0x02. wrap_o is high only in the cycle out_o=0x01.
4. Out-of-range: OUT_N=5, SEL_W=3; load in_sel_i=6 -> out_o=0, out_valid_o=0, err_o=1 for one cycle. A following load of in_sel_i=4 gives out_o=5'b10000 and err_o=0.
5. Pulse mode: PULSE=1; load in_sel_i=2 -> out_o=0x04 for exactly one cycle, then 0 in IDLE. step_i=1 afterwards leaves out_o=0.
6. Priority and asynchronous reset:
   - In SCAN, assert clear_i, in_valid_i (in_sel_i=3) and step_i together -> out_o=0 and IDLE.
   - Next cycle, in_valid_i with step_i -> out_o=0x08 and wrap_o=0.
   - Assert rst mid-cycle -> out_o=0 immediately, before the next clk edge.
